// File: rtl/uesprit_eig2x2.sv
// ---------------------------------------------------------------------------
// uesprit_eig2x2
//
// Dominant eigen-decomposition of the 2x2 real covariance produced by the
// scalar unitary-ESPRIT accumulator. The matrix is
//
//     | r11  r12 |
//     | r12  r22 |
//
// and the block returns, all as exact integers and scaled by 2:
//
//     s       = floor(sqrt((r11 - r22)^2 + 4*r12^2))
//     lambda2 = r11 + r22 + s          (2 * lambda_max)
//     vec_x   = 2 * r12                (eigenvector, component 1)
//     vec_y   = r22 - r11 + s          (eigenvector, component 2, never < 0)
//
// The square root is a restoring, bit-serial engine that produces one result
// bit per cycle, MSB first. The latency is fixed and independent of the data:
// dout_valid rises DIN_WIDTH+4 clock edges after the accepting edge.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset; aborts a running computation
//   r11, r22    unsigned auto-powers of channel 1 and 2
//   r12         signed cross-correlation (real part)
//   din_valid   single-cycle strobe, inputs valid
//   busy        high from the cycle after acceptance through dout_valid
//   lambda2     2 * dominant eigenvalue (unsigned)
//   vec_x       eigenvector component 1 (signed)
//   vec_y       eigenvector component 2 (unsigned)
//   degen       vec_x == 0 and vec_y == 0 (no usable direction)
//   dropped     one-cycle pulse: a din_valid was ignored because busy was high
//   dout_valid  one-cycle result strobe; result outputs hold until the next one
// ---------------------------------------------------------------------------
module uesprit_eig2x2 #(
    parameter int unsigned DIN_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIN_WIDTH-1:0]        r11,
    input  logic [DIN_WIDTH-1:0]        r22,
    input  logic [DIN_WIDTH-1:0]        r12,
    input  logic                        din_valid,
    output logic                        busy,
    output logic [DIN_WIDTH+1:0]        lambda2,
    output logic signed [DIN_WIDTH:0]   vec_x,
    output logic [DIN_WIDTH+1:0]        vec_y,
    output logic                        degen,
    output logic                        dropped,
    output logic                        dout_valid
);

    localparam int unsigned W  = DIN_WIDTH;
    localparam int unsigned DW = 2 * W + 2;          // radicand width
    localparam int unsigned SW = W + 1;              // root width
    localparam int unsigned RW = W + 3;              // stored remainder width
    localparam int unsigned CW = $clog2(W + 2);      // iteration counter width

    typedef enum logic [2:0] {
        StIdle,
        StSqr,
        StSum,
        StRoot,
        StDone
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                 state_q, state_d;

    logic [W-1:0]           r11_q, r11_d;
    logic [W-1:0]           r22_q, r22_d;
    logic [W-1:0]           r12_q, r12_d;

    logic [2*W-1:0]         dsq_q, dsq_d;            // (r11 - r22)^2
    logic [2*W-1:0]         csq_q, csq_d;            // r12^2

    logic [DW-1:0]          rad_q, rad_d;            // radicand, shifted out MSB first
    logic [RW-1:0]          rem_q, rem_d;
    logic [SW-1:0]          root_q, root_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [W+1:0]           lambda2_q, lambda2_d;
    logic signed [W:0]      vec_x_q, vec_x_d;
    logic [W+1:0]           vec_y_q, vec_y_d;
    logic                   degen_q, degen_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   dropped_q, dropped_d;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // The dout_valid cycle still counts as busy, so a strobe there is dropped
    // and the earliest new acceptance is the cycle after it.
    logic accept;

    assign busy   = (state_q != StIdle) || dout_valid_q;
    assign accept = (state_q == StIdle) && !dout_valid_q && din_valid;

    // -----------------------------------------------------------------------
    // Squaring datapath (operands are magnitudes, so unsigned multipliers)
    // -----------------------------------------------------------------------
    logic [W:0]     diff;
    logic [W:0]     diff_neg;
    logic [W-1:0]   d_mag;
    logic [W-1:0]   c_neg;
    logic [W-1:0]   c_mag;
    logic [2*W-1:0] d_ext;
    logic [2*W-1:0] c_ext;

    assign diff     = {1'b0, r11_q} - {1'b0, r22_q};
    assign diff_neg = -diff;
    // |d| <= 2^W - 1, so the magnitude always fits in W bits.
    assign d_mag    = diff[W] ? diff_neg[W-1:0] : diff[W-1:0];
    // |-2^(W-1)| = 2^(W-1) still fits as an unsigned W-bit value.
    assign c_neg    = -r12_q;
    assign c_mag    = r12_q[W-1] ? c_neg : r12_q;
    assign d_ext    = {{W{1'b0}}, d_mag};
    assign c_ext    = {{W{1'b0}}, c_mag};

    // -----------------------------------------------------------------------
    // Restoring square-root step
    // -----------------------------------------------------------------------
    // Bring down the next two radicand bits and try to subtract (4*root + 1).
    // The shifted remainder needs two extra bits; after a subtraction the
    // remainder is at most 2*root, which fits back into RW bits.
    logic [RW+1:0] rem_sh;
    logic [RW+1:0] trial;
    logic          take;

    assign rem_sh = {rem_q, rad_q[DW-1 -: 2]};
    assign trial  = {2'b00, root_q, 2'b01};
    assign take   = (rem_sh >= trial);

    // -----------------------------------------------------------------------
    // Result datapath
    // -----------------------------------------------------------------------
    logic [W+1:0]      lambda2_calc;
    logic signed [W:0] vec_x_calc;
    logic [W+1:0]      vec_y_calc;

    assign lambda2_calc = {2'b00, r11_q} + {2'b00, r22_q} + {1'b0, root_q};
    assign vec_x_calc   = {r12_q, 1'b0};
    // Modular arithmetic is safe: s >= |r11 - r22| keeps the true value >= 0.
    assign vec_y_calc   = {2'b00, r22_q} - {2'b00, r11_q} + {1'b0, root_q};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        r11_d        = r11_q;
        r22_d        = r22_q;
        r12_d        = r12_q;
        dsq_d        = dsq_q;
        csq_d        = csq_q;
        rad_d        = rad_q;
        rem_d        = rem_q;
        root_d       = root_q;
        cnt_d        = cnt_q;
        lambda2_d    = lambda2_q;
        vec_x_d      = vec_x_q;
        vec_y_d      = vec_y_q;
        degen_d      = degen_q;
        dout_valid_d = 1'b0;
        dropped_d    = din_valid && busy;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    r11_d   = r11;
                    r22_d   = r22;
                    r12_d   = r12;
                    state_d = StSqr;
                end
            end

            StSqr: begin
                dsq_d   = d_ext * d_ext;
                csq_d   = c_ext * c_ext;
                state_d = StSum;
            end

            StSum: begin
                rad_d   = {2'b00, dsq_q} + {csq_q, 2'b00};
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = StRoot;
            end

            StRoot: begin
                rad_d = {rad_q[DW-3:0], 2'b00};
                if (take) begin
                    rem_d  = RW'(rem_sh - trial);
                    root_d = {root_q[SW-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[RW-1:0];
                    root_d = {root_q[SW-2:0], 1'b0};
                end
                if (cnt_q == CW'(SW - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                lambda2_d    = lambda2_calc;
                vec_x_d      = vec_x_calc;
                vec_y_d      = vec_y_calc;
                degen_d      = (vec_x_calc == '0) && (vec_y_calc == '0);
                dout_valid_d = 1'b1;
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            r11_q        <= '0;
            r22_q        <= '0;
            r12_q        <= '0;
            dsq_q        <= '0;
            csq_q        <= '0;
            rad_q        <= '0;
            rem_q        <= '0;
            root_q       <= '0;
            cnt_q        <= '0;
            lambda2_q    <= '0;
            vec_x_q      <= '0;
            vec_y_q      <= '0;
            degen_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            r11_q        <= r11_d;
            r22_q        <= r22_d;
            r12_q        <= r12_d;
            dsq_q        <= dsq_d;
            csq_q        <= csq_d;
            rad_q        <= rad_d;
            rem_q        <= rem_d;
            root_q       <= root_d;
            cnt_q        <= cnt_d;
            lambda2_q    <= lambda2_d;
            vec_x_q      <= vec_x_d;
            vec_y_q      <= vec_y_d;
            degen_q      <= degen_d;
            dout_valid_q <= dout_valid_d;
            dropped_q    <= dropped_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign lambda2    = lambda2_q;
    assign vec_x      = vec_x_q;
    assign vec_y      = vec_y_q;
    assign degen      = degen_q;
    assign dout_valid = dout_valid_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_uesprit_eig2x2.sv
// ---------------------------------------------------------------------------
// tb_uesprit_eig2x2
//
// Directed bench for uesprit_eig2x2 (DIN_WIDTH = 32): reset values, the
// hand-worked test vectors, latency, handshake (drop / re-accept), reset
// abort, reset-vs-strobe priority, an extreme vector and a random sweep
// against an independent binary-search square-root model.
// ---------------------------------------------------------------------------
module tb_uesprit_eig2x2;

    localparam int W   = 32;
    localparam int LAT = W + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  r11;
    logic [W-1:0]  r22;
    logic [W-1:0]  r12;
    logic          din_valid;
    logic          busy;
    logic [W+1:0]  lambda2;
    logic [W:0]    vec_x;
    logic [W+1:0]  vec_y;
    logic          degen;
    logic          dropped;
    logic          dout_valid;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    uesprit_eig2x2 #(
        .DIN_WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r11       (r11),
        .r22       (r22),
        .r12       (r12),
        .din_valid (din_valid),
        .busy      (busy),
        .lambda2   (lambda2),
        .vec_x     (vec_x),
        .vec_y     (vec_y),
        .degen     (degen),
        .dropped   (dropped),
        .dout_valid(dout_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges (numbered from 'from') until dout_valid is seen; -1 on timeout.
    task automatic wait_done(input int from, output int lat);
        lat = -1;
        for (int k = from; k <= 80 && lat < 0; k++) begin
            tick();
            if (dout_valid) lat = k;
        end
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, output int lat);
        r11       = a;
        r22       = b;
        r12       = c;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        wait_done(1, lat);
    endtask

    task automatic check_out(input string tag, input longint el, input longint ex,
                             input longint ey, input logic edg);
        logic [W+1:0] l;
        logic [W:0]   x;
        logic [W+1:0] y;
        l = el[W+1:0];
        x = ex[W:0];
        y = ey[W+1:0];
        chk({tag, "/lambda2"}, 64'(lambda2), 64'(l));
        chk({tag, "/vec_x"},   64'(vec_x),   64'(x));
        chk({tag, "/vec_y"},   64'(vec_y),   64'(y));
        chk({tag, "/degen"},   64'(degen),   64'(edg));
    endtask

    // Full transaction: accept, latency, result, then step past the strobe.
    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input longint el, input longint ex,
                             input longint ey, input logic edg);
        int lat;
        apply(a, b, c, lat);
        chk({tag, "/latency"}, 64'(lat), 64'(LAT));
        check_out(tag, el, ex, ey, edg);
        tick();
        chk({tag, "/strobe_low"}, 64'(dout_valid), 64'd0);
        chk({tag, "/idle"},       64'(busy),       64'd0);
    endtask

    // Independent reference: 128-bit arithmetic and a binary-search sqrt.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         output longint el, output longint ex, output longint ey);
        longint       d;
        longint       cs;
        logic [127:0] ad;
        logic [127:0] ac;
        logic [127:0] dd;
        logic [127:0] lo;
        logic [127:0] hi;
        logic [127:0] mid;
        d  = longint'({32'b0, a}) - longint'({32'b0, b});
        cs = longint'(signed'(c));
        ad = (d < 0) ? 128'(-d) : 128'(d);
        ac = (cs < 0) ? 128'(-cs) : 128'(cs);
        dd = ad * ad + 128'd4 * ac * ac;
        lo = '0;
        hi = 128'd1 << 35;
        while (hi - lo > 128'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= dd) lo = mid;
            else hi = mid;
        end
        el = longint'({32'b0, a}) + longint'({32'b0, b}) + longint'(lo[63:0]);
        ey = longint'({32'b0, b}) - longint'({32'b0, a}) + longint'(lo[63:0]);
        ex = 2 * cs;
    endtask

    initial begin
        int          lat;
        int          seen;
        longint      el;
        longint      ex;
        longint      ey;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;

        rst       = 1'b1;
        din_valid = 1'b0;
        r11       = '0;
        r22       = '0;
        r12       = '0;
        repeat (3) tick();

        // Reset state
        chk("rst/busy",       64'(busy),       64'd0);
        chk("rst/dout_valid", 64'(dout_valid), 64'd0);
        chk("rst/dropped",    64'(dropped),    64'd0);
        check_out("rst", 0, 0, 0, 1'b0);
        rst = 1'b0;
        tick();

        // Directed vectors
        run_check("zero",  32'd0,   32'd0,  32'd0,  0,   0,  0,  1'b1);
        run_check("equal", 32'd50,  32'd50, 32'd30, 160, 60, 60, 1'b0);
        run_check("neg",   32'd5,   32'd1,  -32'sd3, 13, -6, 3,  1'b0);
        run_check("diag1", 32'd0,   32'd25, 32'd0,  50,  0,  50, 1'b0);
        run_check("diag2", 32'd100, 32'd36, 32'd0,  200, 0,  0,  1'b1);

        // Handshake: 9,4,6 -> D=169, s=13, lambda2=26, vec_x=12, vec_y=8
        r11       = 32'd9;
        r22       = 32'd4;
        r12       = 32'd6;
        din_valid = 1'b1;
        tick();                                  // accepting edge 0
        din_valid = 1'b0;
        repeat (4) tick();                       // edge 4
        r11       = 32'd1000;
        r22       = 32'd1;
        r12       = 32'd77;
        din_valid = 1'b1;
        tick();                                  // edge 5: strobe while busy
        din_valid = 1'b0;
        chk("hs/dropped_pulse", 64'(dropped), 64'd1);
        chk("hs/busy_at_drop",  64'(busy),    64'd1);
        tick();
        chk("hs/dropped_clear", 64'(dropped), 64'd0);
        wait_done(7, lat);
        chk("hs/latency", 64'(lat), 64'(LAT));
        check_out("hs", 26, 12, 8, 1'b0);
        // Strobe during the dout_valid cycle is dropped; held into the next one it is taken.
        r11       = 32'd5;
        r22       = 32'd1;
        r12       = -32'sd3;
        din_valid = 1'b1;
        tick();
        chk("hs/drop_in_done",   64'(dropped),    64'd1);
        chk("hs/single_result",  64'(dout_valid), 64'd0);
        tick();                                  // accepting edge of the second
        din_valid = 1'b0;
        chk("hs/reaccept_busy", 64'(busy), 64'd1);
        wait_done(1, lat);
        chk("hs2/latency", 64'(lat), 64'(LAT));
        check_out("hs2", 13, -6, 3, 1'b0);
        tick();

        // Reset during ROOT (cycle 10) aborts with no result
        r11       = 32'd70;
        r22       = 32'd20;
        r12       = 32'd9;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort/busy",       64'(busy),       64'd0);
        chk("abort/dout_valid", 64'(dout_valid), 64'd0);
        check_out("abort", 0, 0, 0, 1'b0);
        seen = 0;
        repeat (45) begin
            tick();
            if (dout_valid) seen = 1;
        end
        chk("abort/no_result", 64'(seen), 64'd0);

        // din_valid coincident with rst: nothing latched
        r11       = 32'd7;
        r22       = 32'd3;
        r12       = 32'd2;
        rst       = 1'b1;
        din_valid = 1'b1;
        tick();
        rst       = 1'b0;
        din_valid = 1'b0;
        chk("rstwin/busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (45) begin
            tick();
            if (dout_valid) seen = 1;
        end
        chk("rstwin/no_result", 64'(seen), 64'd0);

        // Extreme corner
        a = 32'hFFFF_FFFF;
        b = 32'd0;
        c = 32'h8000_0000;
        model(a, b, c, el, ex, ey);
        run_check("extreme", a, b, c, el, ex, ey, 1'b0);
        chk("extreme/vec_x_const", 64'(vec_x), 64'(33'h1_0000_0000));

        // Random sweep, mixing full-range and shrunken operands
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            if (i % 4 == 1) a = a >> $urandom_range(31, 0);
            if (i % 4 == 2) b = b >> $urandom_range(31, 0);
            if (i % 4 == 3) c = $urandom_range(1, 0) ? -(c >> $urandom_range(31, 1))
                                                     : (c >> $urandom_range(31, 1));
            model(a, b, c, el, ex, ey);
            run_check("rand", a, b, c, el, ex, ey, (ex == 0) && (ey == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uesprit_eig2x2.md
Name: uesprit_eig2x2

Overview:
- Consumes the accumulated 2x2 real covariance produced by the scalar unitary-ESPRIT accumulator stage. Inputs are r11, r22 (unsigned) and r12 (real part, signed).
- Computes the dominant eigenvalue and an unnormalised dominant eigenvector, scaled by 2, using an iterative bit-serial square root.
- Output feeds the downstream arctan/DOA stage. One result per accumulation frame.

Parameters:
- DIN_WIDTH, 32, width of r11/r22/r12 inputs (accumulator output width).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- r11  in  DIN_WIDTH  unsigned auto-power, channel 1
- r22  in  DIN_WIDTH  unsigned auto-power, channel 2
- r12  in  DIN_WIDTH  signed cross-correlation (real part)
- din_valid  in  1  single-cycle strobe, inputs valid
- busy  out  1  high while a computation is in progress
- lambda2  out  DIN_WIDTH+2  unsigned, 2*lambda_max
- vec_x  out  DIN_WIDTH+1  signed eigenvector component 1
- vec_y  out  DIN_WIDTH+2  unsigned eigenvector component 2
- degen  out  1  high when vec_x==0 and vec_y==0
- dropped  out  1  one-cycle pulse, din_valid ignored because busy
- dout_valid  out  1  one-cycle result strobe

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE. Reset mid-computation aborts the computation and emits no dout_valid.
- Mathematics, all exact integer:
  - d = r11 - r22, signed DIN_WIDTH+1.
  - D = d*d + 4*r12*r12, unsigned 2*DIN_WIDTH+2.
  - s = floor(sqrt(D)), DIN_WIDTH+1 bits.
  - lambda2 = r11 + r22 + s.
  - vec_x = 2*r12.
  - vec_y = r22 - r11 + s. This is always >= 0 because s >= |d|.
  - No saturation is needed; the widths cover the full input range.
- FSM states: IDLE, SQR, SUM, ROOT, DONE.
  - IDLE: when din_valid=1, latch r11/r22/r12 and go to SQR; busy goes high next cycle.
  - SQR: register d*d and r12*r12. 1 cycle.
  - SUM: register D = d^2 + (r12^2 << 2); load the sqrt engine. 1 cycle.
  - ROOT: restoring sqrt, one result bit per cycle, MSB first. Exactly DIN_WIDTH+1 cycles, counted by an internal counter. Remainder width DIN_WIDTH+3.
  - DONE: compute and register lambda2/vec_x/vec_y/degen; assert dout_valid for 1 cycle; return to IDLE.
- Latency: dout_valid is high in the cycle starting DIN_WIDTH+4 edges after the accepting edge (36 for the default). This latency is fixed and independent of the data.
- busy is high from the cycle after acceptance through the dout_valid cycle inclusive. din_valid with busy=1 is ignored and pulses dropped the next cycle. A new din_valid in the cycle right after dout_valid is accepted.
- Outputs hold their last result until the next DONE; only dout_valid and dropped are pulses.
- din_valid coincident with rst: rst wins and nothing is latched.

Test Plan:
- Reset check: r11=r22=r12=0, din_valid pulse -> after 36 cycles lambda2=0, vec_x=0, vec_y=0, degen=1, dout_valid for 1 cycle.
- Equal powers: r11=50, r22=50, r12=30 -> s=60, lambda2=160, vec_x=60, vec_y=60, degen=0; latency exactly 36 cycles from the accept edge.
- Negative correlation with floor sqrt: r11=5, r22=1, r12=-3 -> D=52, s=7, lambda2=13, vec_x=-6, vec_y=3.
- Diagonal matrix:
  - r11=0, r22=25, r12=0 -> lambda2=50, vec_x=0, vec_y=50.
  - r11=100, r22=36, r12=0 -> lambda2=200, vec_x=0, vec_y=0, degen=1.
- Extremes: r11=2^32-1, r22=0, r12=-2^31 -> vec_x=-2^32; lambda2 and vec_y match the bit-exact golden model with no wrap. Also 1000 random vectors checked against the golden model.
- Handshake: din_valid at accept and again 5 cycles later -> second strobe dropped (dropped pulse, busy=1), one result only. Next din_valid in the cycle after dout_valid -> accepted. rst asserted at cycle 10 of ROOT -> no dout_valid, outputs 0, busy=0 next cycle.
